mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: word depth of backing array, power of two.
REQ-002 Parameter WAIT_STATES, default 0: extra cycles inserted before each response, range 0-15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemRead  input  1  read request from control FSM, level, held until mem_ready.
REQ-006 MemWrite  input  1  write request from control FSM, level, held until mem_ready.
REQ-007 addr  input  32  byte address (PC or ALUOut, selected upstream by IorD).
REQ-008 wdata  input  32  store data, LSB-aligned.
REQ-009 size  input  3  funct3 encoding: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-010 rdata  output  32  load data, sign/zero-extended per size, held until next completed read.
REQ-011 mem_ready  output  1  one-cycle pulse marking request completion.
REQ-012 mem_err  output  1  one-cycle pulse, coincident with mem_ready, for a faulted request.

Function
REQ-013 States IDLE, WAIT, RESP; IDLE after reset.
REQ-014 IDLE: MemRead or MemWrite high -> capture addr, wdata, size, op; go WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT: down-counter loaded with WAIT_STATES, decrements each cycle, -> RESP when it reaches 1.
REQ-016 RESP: mem_ready=1 for exactly one cycle, then -> IDLE; request inputs ignored outside IDLE.
REQ-017 Latency: request seen in IDLE at edge N -> mem_ready high during cycle N+1+WAIT_STATES.
REQ-018 Back-to-back: request still asserted in IDLE after RESP is a new request (FSM must drop it on mem_ready).
REQ-019 Write commits to array on the RESP entry edge only; byte lanes from addr[1:0] and size.
REQ-020 Read data from array latched into rdata on the RESP entry edge; byte/half extracted from addr[1:0], sign-extended for 000/001, zero-extended for 100/101.
REQ-021 Fault conditions: MemRead and MemWrite both high; half access with addr[0]=1; word access with addr[1:0]!=0; word index addr[31:2] >= DEPTH_WORDS; size 011/110/111.
REQ-022 Faulted request: same latency, mem_err=1 with mem_ready, no array write, rdata unchanged.
REQ-023 Writes with size 100/101 are faults.
REQ-024 Address index uses addr[2+log2(DEPTH_WORDS)-1:2]; no wrap-around, out-of-range faults per REQ-021.

Reset
REQ-025 reset asserted: state IDLE, counter 0, rdata 0, mem_ready 0, mem_err 0, captured request cleared, immediately and regardless of clk.
REQ-026 reset mid-WAIT or mid-RESP abandons the request; no write commits, no response pulse.
REQ-027 Array contents not reset; initialised by simulation preload only.

Structure
REQ-028 Shared package holds state enum, size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), and a word-aligned check constant.
REQ-029 Array in sub-module mem_array: single port, synchronous write with 4-bit byte enable, combinational read by word index.
REQ-030 mem_responder contains FSM, wait counter, fault logic, lane steering, extension.

Verification
REQ-031 WAIT_STATES=0: write size=010 addr=0x10 wdata=0xDEADBEEF, then read size=010 addr=0x10 -> mem_ready one cycle after each request, rdata=0xDEADBEEF, mem_err=0.
REQ-032 Word 0x10=0xDEADBEEF; read size=000 addr=0x13 -> rdata=0xFFFFFFDE; size=100 addr=0x13 -> rdata=0x000000DE; size=001 addr=0x12 -> 0xFFFFDEAD.
REQ-033 Store size=000 addr=0x11 wdata=0x55 onto 0xDEADBEEF -> subsequent word read returns 0xDEAD55EF.
REQ-034 WAIT_STATES=3: read request -> mem_ready exactly 4 cycles after capture, low in between, single-cycle pulse.
REQ-035 Faults: word read addr=0x2; MemRead+MemWrite together; word write addr=4*DEPTH_WORDS -> mem_ready and mem_err both pulse, array and rdata unchanged.
REQ-036 WAIT_STATES=3: write addr=0x20, assert reset during WAIT -> outputs 0 immediately, no mem_ready, later read of 0x20 returns prior contents.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multi-cycle data memory responder:
// FSM state codes, funct3 size encodings, captured request record and lane helpers.
package mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } req_t;

  function automatic logic size_legal(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_legal = 1'b1;
      default:                        size_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] sz, input logic [1:0] off);
    case (sz[1:0])
      2'b00:   lane_enable = 4'b0001 << off;
      2'b01:   lane_enable = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_enable = 4'b1111;
      default: lane_enable = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: IDLE/WAIT/RESP handshake with optional wait states,
// fault detection, byte-lane steering and load sign/zero extension.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  req_t          cur_s;
  logic          fault_s;
  logic          resp_entry_s;
  logic          we_s;
  logic [1:0]    off_s;
  logic [3:0]    be_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   lane_wdata_s;
  logic [31:0]   arr_rdata_s;
  logic [7:0]    sel_byte_s;
  logic [15:0]   sel_half_s;
  logic [31:0]   ext_s;

  // With zero wait states the RESP entry edge is the capture edge, so live inputs are used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_s.rd    = MemRead;
      cur_s.wr    = MemWrite;
      cur_s.addr  = addr;
      cur_s.wdata = wdata;
      cur_s.size  = size;
    end else begin
      cur_s = req_q;
    end
  end

  // Fault classification of the request being served.
  always_comb begin
    fault_s = 1'b0;
    if (cur_s.rd && cur_s.wr) begin
      fault_s = 1'b1;
    end else if (!size_legal(cur_s.size)) begin
      fault_s = 1'b1;
    end else if (cur_s.wr && cur_s.size[2]) begin
      fault_s = 1'b1;
    end else if ((cur_s.size[1:0] == 2'b01) && cur_s.addr[0]) begin
      fault_s = 1'b1;
    end else if ((cur_s.size[1:0] == 2'b10) && ((cur_s.addr[1:0] & WORD_ALIGN_MASK) != 2'b00)) begin
      fault_s = 1'b1;
    end else if (|cur_s.addr[31:AW+2]) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
  end

  assign off_s = cur_s.addr[1:0];
  assign idx_s = cur_s.addr[AW+1:2];
  assign be_s  = lane_enable(cur_s.size, off_s);

  // Store data replicated onto every lane; byte enables pick the live one.
  always_comb begin
    case (cur_s.size[1:0])
      2'b00:   lane_wdata_s = {4{cur_s.wdata[7:0]}};
      2'b01:   lane_wdata_s = {2{cur_s.wdata[15:0]}};
      default: lane_wdata_s = cur_s.wdata;
    endcase
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (we_s),
    .be    (be_s),
    .idx   (idx_s),
    .wdata (lane_wdata_s),
    .rdata (arr_rdata_s)
  );

  // Load lane extraction and sign/zero extension.
  always_comb begin
    sel_byte_s = arr_rdata_s[8*off_s +: 8];
    sel_half_s = off_s[1] ? arr_rdata_s[31:16] : arr_rdata_s[15:0];
    case (cur_s.size)
      SZ_B:    ext_s = {{24{sel_byte_s[7]}}, sel_byte_s};
      SZ_BU:   ext_s = {24'h000000, sel_byte_s};
      SZ_H:    ext_s = {{16{sel_half_s[15]}}, sel_half_s};
      SZ_HU:   ext_s = {16'h0000, sel_half_s};
      default: ext_s = arr_rdata_s;
    endcase
  end

  // Next-state logic for the handshake FSM and wait counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_entry_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          req_d = cur_s;
          if (WS == 4'd0) begin
            state_d      = ST_RESP;
            resp_entry_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end else begin
          req_d = req_q;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d      = ST_RESP;
          cnt_d        = 4'd0;
          resp_entry_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign we_s    = resp_entry_s && cur_s.wr && !fault_s && !reset;
  assign ready_d = resp_entry_s;
  assign err_d   = resp_entry_s && fault_s;
  assign rdata_d = (resp_entry_s && cur_s.rd && !fault_s) ? ext_s : rdata_q;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign rdata     = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule
